// File: rtl/traffic_light_ctrl.sv
// Two-road (NS/EW) traffic signal controller.
// Tick-timed green/yellow/all-red phases, latched pedestrian requests that
// shorten the opposing green and light the walk lamp, and a night flash mode
// entered from the all-red clearance interval.
module traffic_light_ctrl #(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int MIN_GREEN    = 2,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_ns_req,
  input  logic       ped_ew_req,
  input  logic       flash_en,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6,
    ILL   = 3'd7
  } state_t;

  // Last counter value of each phase (counter runs 0..N-1 within a phase).
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             ns_pend;
  logic             ew_pend;
  logic             flash_ph;
  logic             phase_end;
  logic             enter_ns_g;
  logic             enter_ew_g;

  // Next-state selection: phase end condition per state, advanced only on tick.
  always_comb begin
    state_nx  = state;
    phase_end = 1'b0;
    case (state)
      NS_G:       phase_end = (cnt == G_LAST) || (ew_pend && (cnt >= MG_LAST));
      EW_G:       phase_end = (cnt == G_LAST) || (ns_pend && (cnt >= MG_LAST));
      NS_Y, EW_Y: phase_end = (cnt == Y_LAST);
      AR1, AR2:   phase_end = (cnt == AR_LAST);
      FLASH:      phase_end = !flash_en;
      default:    phase_end = 1'b1;
    endcase
    if (state == ILL) begin
      // The illegal code is left immediately, tick or not, via a clearance phase.
      state_nx = AR2;
    end else if (tick && phase_end) begin
      case (state)
        NS_G:    state_nx = NS_Y;
        NS_Y:    state_nx = AR1;
        AR1:     state_nx = flash_en ? FLASH : EW_G;
        EW_G:    state_nx = EW_Y;
        EW_Y:    state_nx = AR2;
        AR2:     state_nx = flash_en ? FLASH : NS_G;
        FLASH:   state_nx = AR2;
        default: state_nx = AR2;
      endcase
    end
  end

  assign enter_ns_g = (state_nx == NS_G) && (state != NS_G);
  assign enter_ew_g = (state_nx == EW_G) && (state != EW_G);

  // State, phase counter, pedestrian latches, walk lamps and flash phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NS_G;
      cnt      <= '0;
      ns_pend  <= 1'b0;
      ew_pend  <= 1'b0;
      walk_ns  <= 1'b0;
      walk_ew  <= 1'b0;
      flash_ph <= 1'b0;
    end else begin
      state <= state_nx;

      if (state_nx != state) begin
        cnt <= '0;
      end else if (tick && (state != FLASH)) begin
        cnt <= cnt + 1'b1;
      end

      // Requests are dropped in flash mode; the edge entering a road's green
      // consumes both the latched request and any request present on that edge.
      if (state_nx == FLASH) begin
        ns_pend <= 1'b0;
        ew_pend <= 1'b0;
      end else if (state != FLASH) begin
        ns_pend <= enter_ns_g ? 1'b0 : (ns_pend | ped_ns_req);
        ew_pend <= enter_ew_g ? 1'b0 : (ew_pend | ped_ew_req);
      end

      if (enter_ns_g) begin
        walk_ns <= ns_pend | ped_ns_req;
      end else if (state_nx != NS_G) begin
        walk_ns <= 1'b0;
      end

      if (enter_ew_g) begin
        walk_ew <= ew_pend | ped_ew_req;
      end else if (state_nx != EW_G) begin
        walk_ew <= 1'b0;
      end

      if ((state_nx == FLASH) && (state != FLASH)) begin
        flash_ph <= 1'b0;
      end else if ((state == FLASH) && tick) begin
        flash_ph <= ~flash_ph;
      end
    end
  end

  // Lamp decode from the registered state; every non-flash state lights one lamp per road.
  always_comb begin
    ns_g = 1'b0;
    ns_y = 1'b0;
    ns_r = 1'b0;
    ew_g = 1'b0;
    ew_y = 1'b0;
    ew_r = 1'b0;
    case (state)
      NS_G: begin
        ns_g = 1'b1;
        ew_r = 1'b1;
      end
      NS_Y: begin
        ns_y = 1'b1;
        ew_r = 1'b1;
      end
      EW_G: begin
        ns_r = 1'b1;
        ew_g = 1'b1;
      end
      EW_Y: begin
        ns_r = 1'b1;
        ew_y = 1'b1;
      end
      FLASH: begin
        ns_y = flash_ph;
        ew_r = flash_ph;
      end
      default: begin
        ns_r = 1'b1;
        ew_r = 1'b1;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a phase-level reference model
// checked every cycle, plus literal expectations for the scenario points.
module tb_traffic_light_ctrl;

  localparam int G    = 5;
  localparam int Y    = 2;
  localparam int AR   = 1;
  localparam int MING = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_ns_req = 1'b0;
  logic       ped_ew_req = 1'b0;
  logic       flash_en = 1'b0;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic       walk_ns, walk_ew;
  logic [2:0] state_o;

  int n_chk  = 0;
  int n_fail = 0;

  traffic_light_ctrl #(
    .GREEN_TICKS (G),
    .YELLOW_TICKS(Y),
    .ALLRED_TICKS(AR),
    .MIN_GREEN   (MING),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .ped_ns_req(ped_ns_req),
    .ped_ew_req(ped_ew_req),
    .flash_en  (flash_en),
    .ns_g      (ns_g),
    .ns_y      (ns_y),
    .ns_r      (ns_r),
    .ew_g      (ew_g),
    .ew_y      (ew_y),
    .ew_r      (ew_r),
    .walk_ns   (walk_ns),
    .walk_ew   (walk_ew),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Tick strobe: one clk wide every tick_period clocks, updated just after the edge.
  int tick_period = 0;
  int tcnt = 0;
  always @(posedge clk) begin
    #1;
    if (tick_period == 0) begin
      tick = 1'b0;
      tcnt = 0;
    end else begin
      tcnt = (tcnt + 1) % tick_period;
      tick = (tcnt == 0);
    end
  end

  // ---------------- reference model (phase index 0..5 around the ring, 6 = flash)
  int m_ph = 0, m_el = 0, nx = 0;
  bit m_np = 0, m_ep = 0, m_wn = 0, m_we = 0, m_fph = 0, m_valid = 0, last = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_el = 0; m_np = 0; m_ep = 0; m_wn = 0; m_we = 0; m_fph = 0;
      m_valid = 1;
    end else if (m_valid) begin
      nx = m_ph;
      if (m_ph == 6) begin
        if (tick && !flash_en) nx = 5;
      end else if (tick) begin
        case (m_ph)
          0:       last = (m_el + 1 == G) || (m_ep && (m_el + 1 >= MING));
          3:       last = (m_el + 1 == G) || (m_np && (m_el + 1 >= MING));
          1, 4:    last = (m_el + 1 == Y);
          default: last = (m_el + 1 == AR);
        endcase
        if (last) nx = ((m_ph == 2 || m_ph == 5) && flash_en) ? 6 : (m_ph + 1) % 6;
      end
      if (nx == 6) begin
        m_np = 0; m_ep = 0;
      end else if (m_ph != 6) begin
        m_np = m_np | ped_ns_req;
        m_ep = m_ep | ped_ew_req;
      end
      if (nx == 0 && m_ph != 0) begin m_wn = m_np; m_np = 0; end
      else if (nx != 0) m_wn = 0;
      if (nx == 3 && m_ph != 3) begin m_we = m_ep; m_ep = 0; end
      else if (nx != 3) m_we = 0;
      if (nx == 6 && m_ph != 6) m_fph = 0;
      else if (nx == 6 && tick) m_fph = ~m_fph;
      if (nx != m_ph) m_el = 0;
      else if (tick) m_el = m_el + 1;
      m_ph = nx;
    end
  end

  function automatic logic [5:0] exp_lamps(int ph, bit fph);
    case (ph)
      0:       return 6'b100_001;
      1:       return 6'b010_001;
      3:       return 6'b001_100;
      4:       return 6'b001_010;
      6:       return {1'b0, fph, 1'b0, 1'b0, 1'b0, fph};
      default: return 6'b001_001;
    endcase
  endfunction

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    logic [10:0] act, expv;
    if (m_valid) begin
      act  = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew, state_o};
      expv = {exp_lamps(m_ph, m_fph), m_wn, m_we, 3'(m_ph)};
      n_chk++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got %b required %b", $time, act, expv);
      end
      n_chk++;
      if ((ns_g & ew_g) !== 1'b0) begin
        n_fail++;
        $display("FAIL dual_green t=%0t: ns_g=%b ew_g=%b required not both 1", $time, ns_g, ew_g);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, int act, int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic wait_state(int s, int budget);
    int n = 0;
    while (state_o !== 3'(s) && n < budget) begin step(); n++; end
    if (state_o !== 3'(s)) begin
      n_chk++; n_fail++;
      $display("FAIL wait_state: got state %0d required %0d within %0d clk", state_o, s, budget);
    end
  endtask

  task automatic tick_edge();
    bit t;
    int n = 0;
    do begin t = tick; step(); n++; end while (!t && n < 20);
    if (!t) begin
      n_chk++; n_fail++;
      $display("FAIL tick_edge: got no tick required one within 20 clk");
    end
  endtask

  // Ticks spent in state s from now until the DUT leaves it.
  task automatic dwell_ticks(int s, output int dw);
    bit t;
    int n = 0;
    dw = 0;
    while (state_o === 3'(s) && n < 200) begin
      t = tick; step(); n++;
      if (t) dw++;
    end
  endtask

  int seq_s [6];
  int seq_d [6];
  int exp_s [6] = '{0, 1, 2, 3, 4, 5};
  int exp_d [6] = '{5, 2, 1, 5, 2, 1};
  int exp_fy[4] = '{1, 0, 1, 0};

  initial begin
    int dw, k, c, prev;
    bit t;

    // Reset state
    step(); step();
    chk("rst_state", state_o, 0);
    chk("rst_lamps", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}, 6'b100_001);
    chk("rst_walks", {walk_ns, walk_ew}, 0);
    rst = 1'b0;

    // No ticks for 50 clk: nothing may move
    for (int i = 0; i < 50; i++) step();
    chk("hold_state", state_o, 0);
    chk("hold_lamps", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}, 6'b100_001);

    // Full nominal cycle, tick every 4 clk
    tick_period = 4;
    k = 0; dw = 0; prev = int'(state_o);
    for (c = 0; c < 400 && k < 6; c++) begin
      t = tick; step();
      if (t) dw++;
      if (int'(state_o) != prev) begin
        seq_s[k] = prev; seq_d[k] = dw; k++; dw = 0; prev = int'(state_o);
      end
    end
    chk("cycle_transitions", k, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cycle_state_%0d", i), seq_s[i], exp_s[i]);
      chk($sformatf("cycle_dwell_%0d", i), seq_d[i], exp_d[i]);
    end
    chk("cycle_back_to_ns_g", state_o, 0);

    // EW ped request during the first tick of NS_G shortens NS_G to MIN_GREEN
    ped_ew_req = 1'b1;
    t = tick; step();
    ped_ew_req = 1'b0;
    dwell_ticks(0, dw);
    chk("ped_ew_ns_g_dwell", dw + int'(t), 2);
    wait_state(3, 100);
    chk("ped_ew_pend_cleared", int'(dut.ew_pend), 0);
    c = 0;
    while (state_o === 3'd3 && c < 100) begin
      chk("ped_ew_walk_in_ew_g", walk_ew, 1);
      step(); c++;
    end
    chk("ped_ew_walk_off_after", walk_ew, 0);

    // NS ped request late in NS_G waits for the next NS green
    wait_state(0, 100);
    tick_edge(); tick_edge(); tick_edge();
    chk("ped_ns_still_ns_g", state_o, 0);
    ped_ns_req = 1'b1;
    step();
    ped_ns_req = 1'b0;
    c = 0;
    while (state_o === 3'd0 && c < 100) begin
      chk("ped_ns_no_walk_now", walk_ns, 0);
      step(); c++;
    end
    wait_state(3, 100);
    dwell_ticks(3, dw);
    chk("ped_ns_ew_g_short", dw, 2);
    wait_state(0, 100);
    chk("ped_ns_walk_next_green", walk_ns, 1);

    // Flash mode requested during EW_G
    wait_state(3, 200);
    flash_en = 1'b1;
    tick_edge();
    while (state_o === 3'd3) tick_edge();
    chk("flash_seq_ew_y", state_o, 4);
    wait_state(5, 100);
    chk("flash_seq_ar2", state_o, 5);
    wait_state(6, 100);
    chk("flash_entry_lamps", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew}, 0);
    for (int i = 0; i < 4; i++) begin
      tick_edge();
      chk($sformatf("flash_ns_y_%0d", i), ns_y, exp_fy[i]);
      chk($sformatf("flash_ew_r_%0d", i), ew_r, exp_fy[i]);
    end
    flash_en = 1'b0;
    tick_edge();
    chk("flash_exit_ar2", state_o, 5);
    tick_edge();
    chk("flash_exit_ns_g", state_o, 0);

    // Reset in EW_Y
    wait_state(4, 200);
    rst = 1'b1;
    step();
    chk("rst_ew_y_state", state_o, 0);
    chk("rst_ew_y_out", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew}, 8'b100_001_00);
    rst = 1'b0;

    // Reset in FLASH
    flash_en = 1'b1;
    wait_state(6, 300);
    rst = 1'b1;
    step();
    chk("rst_flash_state", state_o, 0);
    chk("rst_flash_out", {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew}, 8'b100_001_00);
    rst = 1'b0;
    flash_en = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
